fc1_top: RTL and testbench
==========================

Name: fc1_top

Overview:
- First fully-connected layer of the BiLSTM localization back-end: y = W·x + b over IN_DIM signed Q4.12 inputs producing OUT_DIM signed Q4.12 outputs.
- Weights and biases live in internal ROMs initialised from memory files.
- Computation is sequential, one multiply-accumulate per cycle, started by a one-cycle start pulse and finished with a one-cycle out_done pulse.
- Sits between the BiLSTM concatenated hidden-state output and the next FC stage.

Parameters:
- DATA_WIDTH, 16, width of inputs, weights, biases and outputs (signed Q4.12).
- ACC_WIDTH, 32, signed accumulator width.
- IN_DIM, 200, input vector length.
- OUT_DIM, 100, output vector length (neurons).
- FRAC_BITS, 12, fractional bits of the Q format.
- WEIGHT_FILE, "fc1_weights.mem", hex file of OUT_DIM*IN_DIM words, row-major, address j*IN_DIM+i.
- BIAS_FILE, "fc1_bias.mem", hex file of OUT_DIM words.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a pass; sampled in IDLE only.
- in_vector  in  signed [DATA_WIDTH-1:0] x [0:IN_DIM-1]  unpacked input array, Q4.12.
- out_vector  out  signed [DATA_WIDTH-1:0] x [0:OUT_DIM-1]  unpacked output array, Q4.12, registered.
- out_done  out  1  one-cycle pulse: all out_vector entries valid.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; out_vector all 0; out_done 0; counters and accumulator 0.
- FSM states: IDLE, MAC, WRITE, DONE.
- IDLE: on start=1, latch all of in_vector into an internal register, clear j=0, i=0, acc=0, go to MAC.
- MAC, per neuron j:
  - Issue ROM address j*IN_DIM+i each cycle, i = 0..IN_DIM-1. ROM is synchronous with 1-cycle read latency.
  - The accumulate stage runs one cycle behind: IN_DIM issue cycles plus 1 drain cycle.
  - Each term: product = w*x (2*DATA_WIDTH signed, Q8.24), arithmetic shift right FRAC_BITS (truncate toward -inf), sign-extend to ACC_WIDTH, add to acc.
- WRITE:
  - sum = acc + sign-extended bias[j].
  - Saturate to [-32768, 32767] (0x8000..0x7FFF).
  - Store to out_vector[j], clear acc.
  - If j==OUT_DIM-1 go to DONE, else j++, i=0, back to MAC.
- DONE: out_done=1 for exactly one cycle, then IDLE.
- Per-neuron cost is IN_DIM+2 cycles. Latency from the clock edge sampling start to out_done high is OUT_DIM*(IN_DIM+2)+1 cycles (20201 at defaults).
- out_vector entries update progressively as each neuron is written. All entries hold stable from out_done until the next pass writes them.
- start while not IDLE is ignored. Input changes after the latch do not affect the pass.
- start in the DONE cycle is ignored; start in the next IDLE cycle is accepted.
- Reset mid-pass aborts immediately, with outputs cleared as above.
- Accumulator never overflows at defaults (200 terms of at most 2^19 each). Wrap behaviour beyond ACC_WIDTH is not required.

Optional Feature:
- Macro FC1_RELU_EN.
- Defined: in WRITE, negative saturated results are replaced by 0 (ReLU) before storing.
- Undefined: the saturated linear result is stored unchanged.
- Latency is identical in both builds.

Decomposition:
- Package fc1_pkg: Q4.12 constants (FRAC_BITS, Q_MAX=16'h7FFF, Q_MIN=16'h8000), FSM state enum, and a saturate function from ACC_WIDTH to DATA_WIDTH.
- One sub-module, fc1_weight_rom: synchronous ROM parameterised by depth, width and init file, used for weights (and a second instance for biases).

Test Plan:
1. Reset, then inputs all 0, weights all 0, biases j*16'h0010 -> after 20201 cycles out_done pulses once; out_vector[j]=16'h0010*j; all outputs 0 during and after reset.
2. x[i]=16'h1000 (1.0), W row j = 16'h0010 in all columns, bias 0 -> every output = 200*16 = 16'h0C80.
3. x[i]=16'h7FFF, W all 16'h7FFF, bias 0 -> out_vector[0]=out_vector[1]=16'h7FFF (positive saturation).
4. x[i]=16'h7FFF, W all 16'h8000 -> all outputs 16'h8000 (negative saturation); with FC1_RELU_EN all outputs 16'h0000.
5. Assert start again 100 cycles into a pass and modify in_vector -> ignored; out_done still at cycle 20201 with results from the originally latched input.
6. Pull rst_n low mid-pass -> out_vector all 0 and out_done 0 immediately; a new start completes normally with correct values.

Source files
------------

// File: rtl/fc1_pkg.sv
// Shared Q4.12 constants, FSM state type and saturation helper for the FC1 layer.
package fc1_pkg;

  localparam int unsigned Q_DATA_W    = 16;
  localparam int unsigned Q_ACC_W     = 32;
  localparam int unsigned Q_FRAC_BITS = 12;

  localparam logic [Q_DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [Q_DATA_W-1:0] Q_MIN = 16'h8000;

  // Q_MAX / Q_MIN sign-extended to accumulator width for range compares
  localparam logic signed [Q_ACC_W-1:0] ACC_Q_MAX = 32'sd32767;
  localparam logic signed [Q_ACC_W-1:0] ACC_Q_MIN = -32'sd32768;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StWrite,
    StDone
  } fc1_state_e;

  // Clamp a wide accumulator value into the Q4.12 output range.
  function automatic logic [Q_DATA_W-1:0] sat_q(input logic signed [Q_ACC_W-1:0] v);
    logic [Q_DATA_W-1:0] r;
    if (v > ACC_Q_MAX) begin
      r = Q_MAX;
    end else if (v < ACC_Q_MIN) begin
      r = Q_MIN;
    end else begin
      r = v[Q_DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fc1_weight_rom.sv
// Synchronous single-port ROM with one-cycle read latency.
// Contents are loaded externally; INIT_FILE is retained as a descriptive parameter.
module fc1_weight_rom #(
  parameter int unsigned DEPTH     = 20000,
  parameter int unsigned WIDTH     = 16,
  parameter string       INIT_FILE = "",
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Registered read port
  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/fc1_top.sv
// FC1 layer: y = W*x + b over Q4.12 data, one MAC per cycle.
// Optional macro FC1_RELU_EN clamps negative results to zero before storing.
module fc1_top
  import fc1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = Q_DATA_W,
  parameter int unsigned ACC_WIDTH   = Q_ACC_W,
  parameter int unsigned IN_DIM      = 200,
  parameter int unsigned OUT_DIM     = 100,
  parameter int unsigned FRAC_BITS   = Q_FRAC_BITS,
  parameter string       WEIGHT_FILE = "fc1_weights.mem",
  parameter string       BIAS_FILE   = "fc1_bias.mem"
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] in_vector  [IN_DIM],
  output logic signed [DATA_WIDTH-1:0] out_vector [OUT_DIM],
  output logic                         out_done
);

  localparam int unsigned CW  = $clog2(IN_DIM + 1);
  localparam int unsigned IW  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int unsigned JW  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int unsigned WD  = OUT_DIM * IN_DIM;
  localparam int unsigned WAW = (WD > 1) ? $clog2(WD) : 1;
  localparam int unsigned PW  = 2 * DATA_WIDTH;

  fc1_state_e state_q, state_d;

  logic signed [DATA_WIDTH-1:0] x_q [IN_DIM];
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [JW-1:0]                j_q, j_d;
  logic [WAW-1:0]               waddr_q, waddr_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] x_term_q, x_term_d;

  logic                         latch_x;
  logic                         wr_en;
  logic [IW-1:0]                i_idx;
  logic [DATA_WIDTH-1:0]        w_raw, b_raw;
  logic signed [DATA_WIDTH-1:0] w_s, b_s;
  logic signed [PW-1:0]         prod, prod_sh;
  logic signed [ACC_WIDTH-1:0]  term, sum;
  logic [DATA_WIDTH-1:0]        res;

  fc1_weight_rom #(
    .DEPTH     (WD),
    .WIDTH     (DATA_WIDTH),
    .INIT_FILE (WEIGHT_FILE)
  ) u_weight_rom (
    .clk  (clk),
    .addr (waddr_q),
    .data (w_raw)
  );

  // Bias address is simply the current neuron; it is stable long before WRITE
  fc1_weight_rom #(
    .DEPTH     (OUT_DIM),
    .WIDTH     (DATA_WIDTH),
    .INIT_FILE (BIAS_FILE)
  ) u_bias_rom (
    .clk  (clk),
    .addr (j_q),
    .data (b_raw)
  );

  assign i_idx = cnt_q[IW-1:0];
  assign w_s   = signed'(w_raw);
  assign b_s   = signed'(b_raw);

  // Q8.24 product truncated toward -inf back to Q4.12, then the output stage
  always_comb begin
    prod    = w_s * x_term_q;
    prod_sh = prod >>> FRAC_BITS;
    term    = ACC_WIDTH'(prod_sh);
    sum     = acc_q + ACC_WIDTH'(b_s);
    res     = sat_q(sum);
`ifdef FC1_RELU_EN
    if (res[DATA_WIDTH-1]) begin
      res = '0;
    end
`endif
  end

  // Next-state and datapath control; weight issue runs one cycle ahead of accumulate
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    j_d      = j_q;
    waddr_d  = waddr_q;
    acc_d    = acc_q;
    x_term_d = x_term_q;
    latch_x  = 1'b0;
    wr_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch_x = 1'b1;
          cnt_d   = '0;
          j_d     = '0;
          waddr_d = '0;
          acc_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        // Issue phase: cnt 0..IN_DIM-1 addresses the ROM and captures x[i]
        if (cnt_q != CW'(IN_DIM)) begin
          x_term_d = x_q[i_idx];
          waddr_d  = waddr_q + 1'b1;
        end
        // Accumulate phase lags by one cycle to meet ROM latency
        if (cnt_q != '0) begin
          acc_d = acc_q + term;
        end
        if (cnt_q == CW'(IN_DIM)) begin
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrite: begin
        wr_en = 1'b1;
        acc_d = '0;
        cnt_d = '0;
        if (j_q == JW'(OUT_DIM - 1)) begin
          state_d = StDone;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = StMac;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      j_q      <= '0;
      waddr_q  <= '0;
      acc_q    <= '0;
      x_term_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      waddr_q  <= waddr_d;
      acc_q    <= acc_d;
      x_term_q <= x_term_d;
    end
  end

  // Input snapshot taken on an accepted start so later input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < IN_DIM; k++) begin
        x_q[k] <= '0;
      end
    end else if (latch_x) begin
      for (int k = 0; k < IN_DIM; k++) begin
        x_q[k] <= in_vector[k];
      end
    end
  end

  // Output registers written one neuron at a time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OUT_DIM; k++) begin
        out_vector[k] <= '0;
      end
    end else if (wr_en) begin
      out_vector[j_q] <= signed'(res);
    end
  end

  // Done pulse follows the DONE state by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_done <= 1'b0;
    end else begin
      out_done <= (state_q == StDone);
    end
  end

endmodule

// File: tb/tb_fc1_top.sv
// Self-checking bench for fc1_top at reduced dimensions; ROM contents loaded hierarchically.
module tb_fc1_top;

  localparam int unsigned DW   = 16;
  localparam int unsigned IN   = 8;
  localparam int unsigned OUT  = 4;
  localparam int unsigned LAT  = OUT * (IN + 2) + 1;
  localparam int unsigned BUDG = LAT + 50;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic signed [DW-1:0] in_vec  [IN];
  logic signed [DW-1:0] out_vec [OUT];
  logic                 out_done;

  logic [DW-1:0] w_tb [OUT*IN];
  logic [DW-1:0] b_tb [OUT];
  logic [DW-1:0] exp_q [$];

  int checks;
  int failures;

  fc1_top #(
    .DATA_WIDTH  (DW),
    .ACC_WIDTH   (32),
    .IN_DIM      (IN),
    .OUT_DIM     (OUT),
    .FRAC_BITS   (12),
    .WEIGHT_FILE (""),
    .BIAS_FILE   ("")
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_vector  (in_vec),
    .out_vector (out_vec),
    .out_done   (out_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic load_roms();
    for (int a = 0; a < OUT * IN; a++) dut.u_weight_rom.mem[a] = w_tb[a];
    for (int j = 0; j < OUT; j++) dut.u_bias_rom.mem[j] = b_tb[j];
  endtask

  // Reference: truncating Q4.12 dot product, bias, saturate, optional ReLU
  task automatic push_expected();
    longint acc;
    int     p;
    logic [DW-1:0] r;
    for (int j = 0; j < OUT; j++) begin
      acc = 0;
      for (int i = 0; i < IN; i++) begin
        p   = int'($signed(w_tb[j*IN+i])) * int'(in_vec[i]);
        p   = p >>> 12;
        acc = acc + longint'(p);
      end
      acc = acc + longint'($signed(b_tb[j]));
      if (acc > 32767) r = 16'h7FFF;
      else if (acc < -32768) r = 16'h8000;
      else r = acc[15:0];
`ifdef FC1_RELU_EN
      if (r[15]) r = 16'h0000;
`endif
      exp_q.push_back(r);
    end
  endtask

  // Run one pass; optionally re-pulse start and scramble inputs mid-pass
  task automatic run_pass(input string name, input int inject_at);
    int cnt;
    bit seen;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    while (cnt < BUDG && !seen) begin
      if (inject_at != 0 && cnt == inject_at) begin
        start = 1'b1;
        for (int i = 0; i < IN; i++) in_vec[i] = DW'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cnt++;
      if (out_done) seen = 1'b1;
    end
    start = 1'b0;
    check_eq({name, "_latency"}, cnt, LAT);
    for (int j = 0; j < OUT; j++) begin
      logic [DW-1:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
      check_eq($sformatf("%s_out%0d", name, j), {16'h0, out_vec[j]}, {16'h0, e});
    end
    @(posedge clk);
    #1;
    check_eq({name, "_done_pulse"}, {31'h0, out_done}, 32'h0);
  endtask

  task automatic fill(input logic [DW-1:0] xv, input logic [DW-1:0] wv, input bit bias_ramp);
    for (int i = 0; i < IN; i++) in_vec[i] = xv;
    for (int a = 0; a < OUT * IN; a++) w_tb[a] = wv;
    for (int j = 0; j < OUT; j++) b_tb[j] = bias_ramp ? DW'(j * 16) : '0;
    load_roms();
  endtask

  task automatic fill_random();
    for (int i = 0; i < IN; i++) in_vec[i] = DW'($urandom);
    for (int a = 0; a < OUT * IN; a++) w_tb[a] = DW'($urandom);
    for (int j = 0; j < OUT; j++) b_tb[j] = DW'($urandom);
    load_roms();
  endtask

  initial begin
    logic [DW-1:0] neg_exp;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    fill(16'h0000, 16'h0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_done", {31'h0, out_done}, 32'h0);
    for (int j = 0; j < OUT; j++) check_eq($sformatf("rst_out%0d", j), {16'h0, out_vec[j]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero weights: outputs are the bias ramp
    run_pass("bias", 0);
    // x = 1.0, w = 16 lsb -> IN*16 per neuron
    fill(16'h1000, 16'h0010, 1'b0);
    run_pass("unit", 0);
    // Positive saturation
    fill(16'h7FFF, 16'h7FFF, 1'b0);
    run_pass("satp", 0);
    // Negative saturation (or ReLU zero)
    fill(16'h7FFF, 16'h8000, 1'b0);
    run_pass("satn", 0);
`ifdef FC1_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'h8000;
`endif
    check_eq("satn_direct", {16'h0, out_vec[OUT-1]}, {16'h0, neg_exp});

    // Restart request and input change mid-pass are ignored
    fill_random();
    run_pass("ignore", 17);

    // Reset mid-pass clears outputs immediately
    fill_random();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_done", {31'h0, out_done}, 32'h0);
    for (int j = 0; j < OUT; j++) check_eq($sformatf("abort_out%0d", j), {16'h0, out_vec[j]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass("after_abort", 0);

    fill_random();
    run_pass("rand", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
